// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding, widths and port indices for the data-memory arbiter
package dmem_pkg;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;
  localparam int BYTE_W = 8;
  localparam int P_CPU = 0;
  localparam int P_LDR = 1;
  typedef enum logic [1:0] {IDLE = 2'd0, LO = 2'd1, HI = 2'd2, DONE = 2'd3} state_e;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester side (req/we/adr/wdata -> done/rdata/stall) and byte-memory side of the arbiter
interface dmem_arbiter_if #(
  parameter int ADDR_W = dmem_pkg::ADDR_W,
  parameter int DATA_W = dmem_pkg::DATA_W
);
  logic [1:0] req, we, done;
  logic [ADDR_W-1:0] adr0, adr1, mem_adr;
  logic [DATA_W-1:0] wdata0, wdata1, rdata, mem_wdata, mem_rdata;
  logic stall, mem_read, mem_write;
  modport slave (
    input req, we, adr0, adr1, wdata0, wdata1, mem_rdata,
    output done, rdata, stall, mem_read, mem_write, mem_adr, mem_wdata
  );
  modport master (
    output req, we, adr0, adr1, wdata0, wdata1, mem_rdata,
    input done, rdata, stall, mem_read, mem_write, mem_adr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: two-way arbiter; ports req_i (requests), en_i (commit grant), gnt_o (winning index)
module rr_arb2 #(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic       gnt_o
);
  logic last_q, last_d;
  always_comb gnt_o = &req_i ? (RR_EN ? ~last_q : 1'b0) : req_i[1];
  always_comb last_d = en_i ? gnt_o : last_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_q <= 1'b1;
    else last_q <= last_d;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a byte-wide data memory between two 16-bit requesters, low byte then high byte
// ports: clk, rst_n (async, active low), bus_if.slave (req/we/adr0/adr1/wdata0/wdata1 in,
//        done/rdata/stall out, mem_read/mem_write/mem_adr/mem_wdata out, mem_rdata in)
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = dmem_pkg::ADDR_W,
  parameter int DATA_W = dmem_pkg::DATA_W,
  parameter int BYTE_W = dmem_pkg::BYTE_W,
  parameter bit RR_EN = 1'b1
) (
  input logic clk,
  input logic rst_n,
  dmem_arbiter_if.slave bus_if
);
  state_e state_q;
  logic sel_q, op_q, gnt, act, hi, unused_hi;
  logic [ADDR_W-1:0] a_q;
  logic [DATA_W-1:0] wd_q, rdata_q;
  logic [BYTE_W-1:0] lo_q;
  logic [1:0] done_q;
  rr_arb2 #(.RR_EN(RR_EN)) u_arb (
    .clk(clk),
    .rst_n(rst_n),
    .req_i(bus_if.req),
    .en_i(state_q == IDLE && |bus_if.req),
    .gnt_o(gnt)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q <= 1'b0;
      op_q <= 1'b0;
      a_q <= '0;
      wd_q <= '0;
      lo_q <= '0;
      rdata_q <= '0;
      done_q <= '0;
    end else begin
      done_q <= '0;
      case (state_q)
        IDLE: if (|bus_if.req) begin
          sel_q <= gnt;
          op_q <= bus_if.we[gnt];
          a_q <= gnt ? bus_if.adr1 : bus_if.adr0;
          wd_q <= gnt ? bus_if.wdata1 : bus_if.wdata0;
          state_q <= LO;
        end
        LO: begin
          if (!op_q) lo_q <= bus_if.mem_rdata[BYTE_W-1:0];
          state_q <= HI;
        end
        HI: begin
          if (!op_q) rdata_q <= {bus_if.mem_rdata[BYTE_W-1:0], lo_q};
          done_q <= sel_q ? 2'b10 : 2'b01;
          state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  // memory strobes are pure decodes of the state, so an async reset drops them at once
  assign act = state_q == LO || state_q == HI;
  assign hi = state_q == HI;
  assign bus_if.mem_read = act & ~op_q;
  assign bus_if.mem_write = act & op_q;
  assign bus_if.mem_adr = act ? a_q + ADDR_W'(hi) : '0;
  assign bus_if.mem_wdata = act ? DATA_W'(hi ? wd_q[DATA_W-1:BYTE_W] : wd_q[BYTE_W-1:0]) : '0;
  assign bus_if.done = done_q;
  assign bus_if.rdata = rdata_q;
  assign bus_if.stall = bus_if.req[P_CPU] & ~done_q[P_CPU];
  assign unused_hi = ^bus_if.mem_rdata[DATA_W-1:BYTE_W];
endmodule
